// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the RV32M multiply/divide unit.
interface riscv_muldiv_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
);
  logic              start;
  logic              flush;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [TAG_W-1:0]  tag_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    output start, flush, funct3, op_a, op_b, tag_in,
    input  busy, done, result, tag_out
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, tag_in,
    output busy, done, result, tag_out
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one step per cycle on operand magnitudes with sign fix-up in FIN.
// Optional macro MULDIV_FAST_MUL_EN: multiplies skip RUN and use a
// combinational product registered in FIN (divide latency unchanged).
module riscv_muldiv_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input logic               clk,
  input logic               reset,
  riscv_muldiv_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]          state, state_nxt;
  logic [2:0]          f3;
  logic [TAG_W-1:0]    tag;
  logic [DATA_W-1:0]   a_lat;
  logic [DATA_W-1:0]   opnd;
  logic [2*DATA_W-1:0] acc;
  logic [CNT_W-1:0]    cnt;
  logic                neg_q, neg_r, div0, ovf;

  logic                accept;
  logic                in_div, a_sgn, b_sgn, in_a_neg, in_b_neg;
  logic                in_div0, in_ovf, in_skip;
  logic [DATA_W-1:0]   in_mag_a, in_mag_b;

  logic [DATA_W:0]     mul_sum, rem_sh;
  logic [DATA_W-1:0]   rem_sub, rem_new;
  logic                rem_ge;
  logic [2*DATA_W-1:0] acc_step;

  logic [2*DATA_W-1:0] prod_mag, prod;
  logic [DATA_W-1:0]   quo, rem, fin_res;

  // Decode the incoming request: signedness, magnitudes and special divides.
  always_comb begin
    accept   = bus.start & ~bus.flush;
    in_div   = bus.funct3[2];
    a_sgn    = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    b_sgn    = bus.funct3 inside {3'b001, 3'b100, 3'b110};
    in_a_neg = a_sgn & bus.op_a[DATA_W-1];
    in_b_neg = b_sgn & bus.op_b[DATA_W-1];
    in_mag_a = in_a_neg ? -bus.op_a : bus.op_a;
    in_mag_b = in_b_neg ? -bus.op_b : bus.op_b;
    in_div0  = in_div & (bus.op_b == '0);
    in_ovf   = in_div & ~bus.funct3[0] & (bus.op_a == MIN_NEG) & (bus.op_b == '1);
`ifdef MULDIV_FAST_MUL_EN
    in_skip  = in_div0 | in_ovf | ~in_div;
`else
    in_skip  = in_div0 | in_ovf;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = in_skip ? FIN : RUN;
      RUN: begin
        if (bus.flush)                          state_nxt = IDLE;
        else if (cnt == CNT_W'(DATA_W - 1))     state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    rem_ge   = rem_sh >= {1'b0, opnd};
    rem_sub  = DATA_W'(rem_sh - {1'b0, opnd});
    rem_new  = rem_ge ? rem_sub : rem_sh[DATA_W-1:0];
    acc_step = f3[2] ? {rem_new, acc[DATA_W-2:0], rem_ge}
                     : {mul_sum, acc[DATA_W-1:1]};
  end

  // Sign correction and result select for FIN.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod_mag = {{DATA_W{1'b0}}, opnd} * {{DATA_W{1'b0}}, acc[DATA_W-1:0]};
`else
    prod_mag = acc;
`endif
    prod = neg_q ? -prod_mag : prod_mag;
    quo  = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    rem  = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    case (f3)
      3'b000:                 fin_res = prod[DATA_W-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*DATA_W-1:DATA_W];
      3'b100, 3'b101:         fin_res = div0 ? '1 : (ovf ? MIN_NEG : quo);
      default:                fin_res = div0 ? a_lat : (ovf ? '0 : rem);
    endcase
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3          <= '0;
      tag         <= '0;
      a_lat       <= '0;
      opnd        <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div0        <= 1'b0;
      ovf         <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.result  <= '0;
      bus.tag_out <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            f3       <= bus.funct3;
            tag      <= bus.tag_in;
            a_lat    <= bus.op_a;
            opnd     <= in_div ? in_mag_b : in_mag_a;
            acc      <= {{DATA_W{1'b0}}, (in_div ? in_mag_a : in_mag_b)};
            cnt      <= '0;
            neg_q    <= in_a_neg ^ in_b_neg;
            neg_r    <= in_a_neg;
            div0     <= in_div0;
            ovf      <= in_ovf;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          if (bus.flush) begin
            bus.busy <= 1'b0;
          end else begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIN: begin
          bus.busy <= 1'b0;
          if (!bus.flush) begin
            bus.result  <= fin_res;
            bus.tag_out <= tag;
            bus.done    <= 1'b1;
          end
        end
        default: bus.busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench for riscv_muldiv_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_riscv_muldiv_unit;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  riscv_muldiv_unit_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();
  riscv_muldiv_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RV32M semantics computed with plain wide integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    sp = 0;
    case (f)
      3'd0: begin sp = sa * sb; r = sp[31:0]; end
      3'd1: begin sp = sa * sb; r = sp[63:32]; end
      3'd2: begin sp = sa * longint'({32'd0, b}); r = sp[63:32]; end
      3'd3: r = up[63:32];
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin sp = sa / sb; r = sp[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin sp = sa % sb; r = sp[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Issue one op and follow it to done; optionally hold start high while busy.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input bit hold, input bit idle_after);
    int          lat;
    bit          busy_ok;
    logic [31:0] exp;
    exp = ref_res(f, a, b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.tag_in = t;
    @(posedge clk);
    #1;
    bus.start  = hold;
    bus.funct3 = 3'($urandom);
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    bus.tag_in = 5'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    check("busy_in_flight", 64'(busy_ok), 64'd1);
    check("latency", 64'(lat), 64'(ref_lat(f, a, b)));
    check("done", 64'(bus.done), 64'd1);
    check("result", 64'(bus.result), 64'(exp));
    check("tag_out", 64'(bus.tag_out), 64'(t));
    check("busy_at_done", 64'(bus.busy), 64'd0);
    if (idle_after) begin
      @(posedge clk);
      #1;
      check("done_pulse", 64'(bus.done), 64'd0);
      check("result_held", 64'(bus.result), 64'(exp));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;
    bit          saw_done;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.tag_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_tag", 64'(bus.tag_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed arithmetic corners.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b0, 1'b1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0, 1'b1);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd10, 1'b0, 1'b1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b0, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12, 1'b0, 1'b1);
    run_op(3'd5, 32'd5, 32'd0, 5'd13, 1'b0, 1'b1);
    run_op(3'd7, 32'd5, 32'd0, 5'd14, 1'b0, 1'b1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0, 1'b1);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 5'd17, 1'b1, 1'b1);
    run_op(3'd4, 32'd100, 32'hFFFF_FFF9, 5'd18, 1'b1, 1'b1);

    // Flush mid-divide: unit goes idle, no done, outputs keep old values.
    prev_res = bus.result;
    prev_tag = bus.tag_out;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd5;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    bus.tag_in = 5'd20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_done", 64'(bus.done), 64'd0);
    check("flush_result", 64'(bus.result), 64'(prev_res));
    check("flush_tag", 64'(bus.tag_out), 64'(prev_tag));
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    check("flush_no_done", 64'(saw_done), 64'd0);

    // Flush beats start in the same cycle.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.funct3 = 3'd4;
    bus.op_a   = 32'd50;
    bus.op_b   = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_vs_start", 64'(bus.busy), 64'd0);

    // Reset mid-RUN clears every output immediately.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd4;
    bus.op_a   = 32'd1000;
    bus.op_b   = 32'd3;
    bus.tag_in = 5'd21;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_result", 64'(bus.result), 64'd0);
    check("mid_rst_tag", 64'(bus.tag_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd7, 32'd1000, 32'd3, 5'd22, 1'b0, 1'b1);

    // Randomized ops, biased toward divide special cases and small values.
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 20) - 10; rb = $urandom_range(0, 20) - 10; end
        default: ;
      endcase
      run_op(rf, ra, rb, 5'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
